// File: rtl/spi_wb_host_master.sv
// spi_wb_host_master: SPI mode-3 host that frames read/write transactions
// for the SPI-to-Wishbone bridge slave. Frame layout:
//   cmd, addr[31:0] MSB first, len[15:0] MSB first, data bytes, tail pad bytes.
// Write data comes in on a valid/ready byte stream; read data leaves on a
// one-cycle valid pulse per byte.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | CS high, SCLK high; waits for i_start
// S_LOAD  | picks the next byte; stalls here for write data (o_tx_ready=1)
// S_SHIFT | 8 SCLK periods; MOSI changes on falling, MISO sampled on rising
// S_GAP   | SCLK high, CS low between bytes for GAP_CLKS cycles
// S_DONE  | CS high, o_done pulse, o_busy already low; back to S_IDLE
//
// CLK_DIV must be >= 2 and GAP_CLKS >= 1.
module spi_wb_host_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CLKS   = 2,
  parameter int TAIL_BYTES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_clk,
  output logic        o_spi_cs,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int TAIL_W = (TAIL_BYTES > 0) ? $clog2(TAIL_BYTES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_DATA,
    P_TAIL
  } phase_t;

  state_t              state;
  phase_t              phase;
  logic                wr_q;
  logic [31:0]         addr_q;
  logic [15:0]         len_q;
  logic [2:0]          hdr_idx;
  logic [15:0]         data_left;
  logic [TAIL_W-1:0]   tail_left;
  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          edge_left;
  logic [GAP_W-1:0]    gap_cnt;
  logic                last_byte;
  logic [7:0]          sr;
  logic                rx_pend;

  logic [7:0]          hdr_byte;
  logic [7:0]          load_byte;
  logic                load_go;

  // Header byte selected by position within the 7-byte header.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = wr_q ? 8'hA2 : 8'hA1;
      3'd1:    hdr_byte = addr_q[31:24];
      3'd2:    hdr_byte = addr_q[23:16];
      3'd3:    hdr_byte = addr_q[15:8];
      3'd4:    hdr_byte = addr_q[7:0];
      3'd5:    hdr_byte = len_q[15:8];
      3'd6:    hdr_byte = len_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Byte to shift next, and whether LOAD may leave this cycle.
  always_comb begin
    load_byte = 8'h00;
    load_go   = 1'b0;
    if (state == S_LOAD) begin
      case (phase)
        P_HDR: begin
          load_byte = hdr_byte;
          load_go   = 1'b1;
        end
        P_DATA: begin
          load_byte = wr_q ? i_tx_data : 8'h00;
          load_go   = wr_q ? i_tx_valid : 1'b1;
        end
        default: begin
          load_byte = 8'h00;
          load_go   = 1'b1;
        end
      endcase
    end
  end

  // Transaction sequencer: framing, SCLK generation, shifting and handshakes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      phase      <= P_HDR;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      hdr_idx    <= '0;
      data_left  <= '0;
      tail_left  <= '0;
      div_cnt    <= '0;
      edge_left  <= '0;
      gap_cnt    <= '0;
      last_byte  <= 1'b0;
      sr         <= '0;
      rx_pend    <= 1'b0;
      o_tx_ready <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_spi_clk  <= 1'b1;
      o_spi_cs   <= 1'b1;
      o_spi_mosi <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_rx_valid <= 1'b0;
      rx_pend    <= 1'b0;
      // Read byte is published the cycle after its 8th rising edge.
      if (rx_pend) begin
        o_rx_valid <= 1'b1;
        o_rx_data  <= sr;
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            wr_q      <= i_write;
            addr_q    <= i_addr;
            len_q     <= i_len;
            phase     <= P_HDR;
            hdr_idx   <= '0;
            last_byte <= 1'b0;
            o_busy    <= 1'b1;
            o_spi_cs  <= 1'b0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (load_go) begin
            sr         <= load_byte;
            o_spi_mosi <= load_byte[7];
            o_tx_ready <= 1'b0;
            div_cnt    <= DIV_W'(CLK_DIV - 1);
            edge_left  <= 5'd16;
            state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt   <= DIV_W'(CLK_DIV - 1);
            o_spi_clk <= ~o_spi_clk;
            edge_left <= edge_left - 5'd1;
            if (o_spi_clk) begin
              // Falling edge: present the current MSB (bit 7 on the first).
              o_spi_mosi <= sr[7];
            end else begin
              // Rising edge: capture MISO; shifting also exposes the next MOSI bit.
              sr <= {sr[6:0], i_spi_miso};
              if (edge_left == 5'd1) begin
                rx_pend <= (phase == P_DATA) && !wr_q;
                gap_cnt <= GAP_W'(GAP_CLKS - 1);
                state   <= S_GAP;
                case (phase)
                  P_HDR: begin
                    if (hdr_idx == 3'd6) begin
                      if (len_q != 16'd0) begin
                        phase     <= P_DATA;
                        data_left <= len_q;
                      end else if (TAIL_BYTES > 0) begin
                        phase     <= P_TAIL;
                        tail_left <= TAIL_W'(TAIL_BYTES);
                      end else begin
                        last_byte <= 1'b1;
                      end
                    end else begin
                      hdr_idx <= hdr_idx + 3'd1;
                    end
                  end
                  P_DATA: begin
                    if (data_left == 16'd1) begin
                      if (TAIL_BYTES > 0) begin
                        phase     <= P_TAIL;
                        tail_left <= TAIL_W'(TAIL_BYTES);
                      end else begin
                        last_byte <= 1'b1;
                      end
                    end else begin
                      data_left <= data_left - 16'd1;
                    end
                  end
                  default: begin
                    if (tail_left == TAIL_W'(1)) begin
                      last_byte <= 1'b1;
                    end else begin
                      tail_left <= tail_left - TAIL_W'(1);
                    end
                  end
                endcase
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            if (last_byte) begin
              o_spi_cs   <= 1'b1;
              o_spi_mosi <= 1'b0;
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              state      <= S_DONE;
            end else begin
              o_tx_ready <= (phase == P_DATA) && wr_q;
              state      <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          last_byte <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wb_host_master.sv
// Bench for spi_wb_host_master: an SPI slave model records MOSI bytes and
// plays MISO bytes from a pattern table; the expected frame, read data,
// handshake count and CS-low duration are built from the framing rules.
module tb_spi_wb_host_master;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CLKS   = 2;
  localparam int TAIL_BYTES = 2;
  localparam int BYTE_CLKS  = 1 + 16 * CLK_DIV + GAP_CLKS;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_write;
  logic [31:0] i_addr;
  logic [15:0] i_len;
  logic [7:0]  i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_spi_clk;
  logic        o_spi_cs;
  logic        o_spi_mosi;
  logic        i_spi_miso;

  spi_wb_host_master #(
    .CLK_DIV(CLK_DIV), .GAP_CLKS(GAP_CLKS), .TAIL_BYTES(TAIL_BYTES)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_write(i_write),
    .i_addr(i_addr), .i_len(i_len), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_busy(o_busy), .o_done(o_done), .o_spi_clk(o_spi_clk), .o_spi_cs(o_spi_cs),
    .o_spi_mosi(o_spi_mosi), .i_spi_miso(i_spi_miso)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // slave model / monitor state
  logic [7:0] miso_pat [64];
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mosi_sh;
  logic [7:0] tmp_b;
  bit  prev_cs = 1'b1;
  bit  prev_sclk = 1'b1;
  int  cs_falls, cs_low, fall_k, rise_k, low_w, width_err, stall_err, done_cnt;
  bit  busy_at_done;

  // write stream source
  logic [7:0] tx_q[$];
  logic [7:0] wr_src[$];
  int  hs_cnt, rdy_cycles, stall_left, stall_mode;
  bit  stall;

  // SPI slave: drive MISO on SCLK fall, record MOSI on SCLK rise; also log
  // rx pulses, done pulses, CS activity and SCLK low-phase widths.
  always @(posedge i_clk) begin
    #1;
    if (prev_cs && !o_spi_cs) begin
      cs_falls++;
      fall_k = 0;
      rise_k = 0;
    end
    if (!o_spi_cs) cs_low++;
    if (prev_sclk && !o_spi_clk) begin
      low_w = 1;
      if (!o_spi_cs && fall_k < 512) begin
        tmp_b = miso_pat[fall_k / 8];
        i_spi_miso = tmp_b[7 - (fall_k % 8)];
      end
      fall_k++;
    end else if (!o_spi_clk) begin
      low_w++;
    end
    if (!prev_sclk && o_spi_clk) begin
      if (low_w != CLK_DIV) width_err++;
      mosi_sh = {mosi_sh[6:0], o_spi_mosi};
      rise_k++;
      if (rise_k % 8 == 0) mosi_q.push_back(mosi_sh);
    end
    if (o_tx_ready && !(o_spi_clk && !o_spi_cs)) stall_err++;
    if (o_rx_valid) rx_q.push_back(o_rx_data);
    if (o_done) begin
      done_cnt++;
      busy_at_done = o_busy;
    end
    prev_cs   = o_spi_cs;
    prev_sclk = o_spi_clk;
  end

  // Write byte source with optional withholding.
  always @(posedge i_clk) begin
    #1;
    stall = 1'b0;
    if (stall_mode == 1 && hs_cnt == 1 && stall_left > 0) begin
      stall = 1'b1;
      if (o_tx_ready) stall_left--;
    end else if (stall_mode == 2 && $urandom_range(0, 3) == 0) begin
      stall = 1'b1;
    end
    if (o_tx_ready) rdy_cycles++;
    if (tx_q.size() > 0 && !stall) begin
      i_tx_valid = 1'b1;
      i_tx_data  = tx_q[0];
    end else begin
      i_tx_valid = 1'b0;
    end
    if (i_tx_valid && o_tx_ready) begin
      void'(tx_q.pop_front());
      hs_cnt++;
    end
  end

  task automatic clear_mon();
    mosi_q.delete();
    rx_q.delete();
    cs_falls = 0; cs_low = 0; fall_k = 0; rise_k = 0; width_err = 0;
    stall_err = 0; done_cnt = 0; busy_at_done = 1'b1;
    hs_cnt = 0; rdy_cycles = 0;
  endtask

  task automatic fill_miso();
    for (int i = 0; i < 64; i++) miso_pat[i] = 8'($urandom);
  endtask

  // Run one frame and compare everything observed with the framing rules.
  task automatic run_frame(input bit wr, input logic [31:0] addr, input logic [15:0] len,
                           input int smode, input bit extra);
    logic [7:0] exp_q[$];
    int nbytes, bound;
    exp_q.delete();
    exp_q.push_back(wr ? 8'hA2 : 8'hA1);
    exp_q.push_back(addr[31:24]); exp_q.push_back(addr[23:16]);
    exp_q.push_back(addr[15:8]);  exp_q.push_back(addr[7:0]);
    exp_q.push_back(len[15:8]);   exp_q.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(wr ? wr_src[i] : 8'h00);
    for (int i = 0; i < TAIL_BYTES; i++) exp_q.push_back(8'h00);
    nbytes = exp_q.size();

    clear_mon();
    tx_q.delete();
    if (wr) tx_q = wr_src;
    stall_mode = smode;
    stall_left = 50;

    @(posedge i_clk); #1;
    i_write = wr; i_addr = addr; i_len = len; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);

    bound = nbytes * (BYTE_CLKS + 8) + 400;
    for (int c = 0; c < bound && done_cnt == 0; c++) begin
      @(posedge i_clk); #1;
      if (extra && c == 100) begin
        i_start = 1'b1; i_write = ~wr; i_addr = ~addr; i_len = len + 16'd3;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    chk("done_seen", done_cnt > 0, 1);
    repeat (12) @(posedge i_clk);
    #1;

    chk("done_pulses", done_cnt, 1);
    chk("busy_low_at_done", busy_at_done, 0);
    chk("busy_idle", o_busy, 0);
    chk("cs_idle", o_spi_cs, 1);
    chk("cs_falls", cs_falls, 1);
    chk("mosi_count", mosi_q.size(), nbytes);
    for (int i = 0; i < nbytes && i < mosi_q.size(); i++)
      chk($sformatf("mosi_byte%0d", i), mosi_q[i], exp_q[i]);
    chk("rx_count", rx_q.size(), wr ? 0 : int'(len));
    for (int i = 0; i < rx_q.size() && !wr && i < int'(len); i++)
      chk($sformatf("rx_byte%0d", i), rx_q[i], miso_pat[7 + i]);
    chk("tx_handshakes", hs_cnt, wr ? int'(len) : 0);
    chk("sclk_low_width", width_err, 0);
    chk("stall_sclk_cs", stall_err, 0);
    chk("cs_low_cycles", cs_low, nbytes * BYTE_CLKS + (rdy_cycles - hs_cnt));
    stall_mode = 0;
  endtask

  logic [31:0] r_addr;
  logic [15:0] r_len;
  bit          r_wr;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_write = 1'b0; i_addr = '0; i_len = '0;
    i_tx_data = '0; i_tx_valid = 1'b0; i_spi_miso = 1'b0;
    stall_mode = 0; stall_left = 0;
    clear_mon();
    fill_miso();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_sclk", o_spi_clk, 1);
    chk("rst_cs", o_spi_cs, 1);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rx_valid", o_rx_valid, 0);
    chk("rst_tx_ready", o_tx_ready, 0);
    chk("rst_rx_data", o_rx_data, 0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);

    // directed read with slave returning DE AD BE EF
    fill_miso();
    miso_pat[7] = 8'hDE; miso_pat[8] = 8'hAD; miso_pat[9] = 8'hBE; miso_pat[10] = 8'hEF;
    run_frame(1'b0, 32'h11223344, 16'd4, 0, 1'b0);

    // directed write, stream always valid
    fill_miso();
    wr_src = '{8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(1'b1, 32'h11223344, 16'd4, 0, 1'b0);

    // write with the 2nd data byte withheld for 50 waiting cycles
    run_frame(1'b1, 32'h11223344, 16'd4, 1, 1'b0);
    chk("stall_applied", stall_left, 0);

    // zero-length read with a second start while busy
    fill_miso();
    run_frame(1'b0, 32'h11223344, 16'd0, 0, 1'b1);

    // reset during the 3rd byte
    clear_mon();
    tx_q.delete();
    @(posedge i_clk); #1;
    i_write = 1'b0; i_addr = 32'hCAFE0001; i_len = 16'd4; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int c = 0; c < 2000 && rise_k < 18; c++) begin
      @(posedge i_clk); #1;
    end
    chk("rst_reached_byte3", rise_k >= 18, 1);
    #2 i_reset = 1'b1;
    #1;
    chk("abort_cs", o_spi_cs, 1);
    chk("abort_sclk", o_spi_clk, 1);
    chk("abort_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_cs_stays_high", o_spi_cs, 1);
    fill_miso();
    run_frame(1'b0, 32'h0BAD_F00D, 16'd3, 0, 1'b0);

    // randomized frames
    for (int n = 0; n < 8; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      r_len  = 16'($urandom_range(0, 12));
      fill_miso();
      wr_src.delete();
      for (int i = 0; i < int'(r_len); i++) wr_src.push_back(8'($urandom));
      run_frame(r_wr, r_addr, r_len, r_wr ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
